// File: rtl/hazard_ctrl_pkg.sv
// Shared state encodings and opcode constants for the IF/ID hazard controller.
// hazard_ctrl optionally adds performance counters when HAZARD_PERF_EN is defined.
package hazard_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_RUN    = 3'd1,
    ST_LSTALL = 3'd2,
    ST_BFLUSH = 3'd3,
    ST_IWAIT  = 3'd4
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Combinational load-use detector: decides which ID sources are real reads
// and whether the load in EX writes one of them.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic       mem_read_ex_i,
  input  logic [4:0] rd_ex_i,
  input  logic [4:0] rs1_id_i,
  input  logic [4:0] rs2_id_i,
  input  logic [6:0] opcode_id_i,
  output logic       load_use_o
);

  logic uses_rs1;
  logic uses_rs2;

  assign uses_rs1 = !((opcode_id_i == OP_LUI) || (opcode_id_i == OP_AUIPC) ||
                      (opcode_id_i == OP_JAL));
  assign uses_rs2 = (opcode_id_i == OP_RTYPE) || (opcode_id_i == OP_STORE) ||
                    (opcode_id_i == OP_BRANCH);

  // x0 is never a real dependency, even when a load names it.
  assign load_use_o = mem_read_ex_i && (rd_ex_i != 5'd0) &&
                      (((rd_ex_i == rs1_id_i) && uses_rs1) ||
                       ((rd_ex_i == rs2_id_i) && uses_rs2));

endmodule

// File: rtl/hazard_ctrl.sv
// IF/ID front-end hazard sequencer with Mealy output decode.
// Define HAZARD_PERF_EN to add the stall_cycles / flush_events counters.
//
// state  | meaning
// RST    | pipeline held and both stage registers flushed
// RUN    | normal flow, all hazards checked
// LSTALL | cycle after a load-use stall; EX holds a bubble
// BFLUSH | cycle after a taken branch; EX holds a bubble
// IWAIT  | waiting for instruction memory
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_EX,
  input  logic [4:0]  RD_EX,
  input  logic [4:0]  RS1_ID,
  input  logic [4:0]  RS2_ID,
  input  logic [6:0]  OPCODE_ID,
  input  logic        PCSrc_EX,
  input  logic        imem_ready,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic [2:0]  state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  state_e state_q, state_d;
  logic   load_use;

  hazard_detect u_detect (
    .mem_read_ex_i (MemRead_EX),
    .rd_ex_i       (RD_EX),
    .rs1_id_i      (RS1_ID),
    .rs2_id_i      (RS2_ID),
    .opcode_id_i   (OPCODE_ID),
    .load_use_o    (load_use)
  );

  always_comb begin
    state_d     = state_q;
    PC_write    = 1'b1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    // Reset overrides the decode so the front end is held before the first edge too.
    if (!reset) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      state_d     = ST_RST;
    end else begin
      case (state_q)
        ST_RST: begin
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
          state_d     = ST_RUN;
        end
        ST_RUN, ST_LSTALL, ST_BFLUSH: begin
          if (PCSrc_EX && (state_q != ST_BFLUSH)) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            state_d     = ST_BFLUSH;
          end else if (!imem_ready) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            state_d     = ST_IWAIT;
          end else if (load_use && (state_q == ST_RUN)) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            state_d     = ST_LSTALL;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_IWAIT: begin
          if (PCSrc_EX) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            state_d     = ST_BFLUSH;
          end else if (!imem_ready) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            state_d     = ST_IWAIT;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
          state_d     = ST_RST;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_RST;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else if (state_q != ST_RST) begin
      if (!PC_write)  stall_q <= stall_q + 32'd1;
      if (IF_ID_flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// against a pipeline-level reference model. Counter checks need HAZARD_PERF_EN.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_EX;
  logic [4:0]  RD_EX, RS1_ID, RS2_ID;
  logic [6:0]  OPCODE_ID;
  logic        PCSrc_EX, imem_ready;
  logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush;
  logic [2:0]  state_o;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  localparam logic [2:0] S_RST = 3'd0, S_RUN = 3'd1, S_LSTALL = 3'd2,
                         S_BFLUSH = 3'd3, S_IWAIT = 3'd4;

  int n_cmp = 0;
  int n_err = 0;

  // Model: remembers what the previous cycle did to the pipeline.
  bit          m_first, m_br, m_ls, m_wt;
  logic [31:0] m_stall, m_flush;
  logic        e_pcw, e_ifw, e_iff, e_ief;
  logic [2:0]  e_state;
  int          ev;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .MemRead_EX(MemRead_EX), .RD_EX(RD_EX),
    .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .OPCODE_ID(OPCODE_ID),
    .PCSrc_EX(PCSrc_EX), .imem_ready(imem_ready), .PC_write(PC_write),
    .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush), .state_o(state_o)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit tb_load_use();
    bit r1 = !(OPCODE_ID inside {7'b0110111, 7'b0010111, 7'b1101111});
    bit r2 = OPCODE_ID inside {7'b0110011, 7'b0100011, 7'b1100011};
    return MemRead_EX && (RD_EX != 5'd0) &&
           (((RD_EX == RS1_ID) && r1) || ((RD_EX == RS2_ID) && r2));
  endfunction

  function automatic void model_eval();
    e_state = m_first ? S_RST : m_br ? S_BFLUSH : m_wt ? S_IWAIT :
              m_ls ? S_LSTALL : S_RUN;
    ev = 0;
    if (!reset || m_first)          {e_pcw, e_ifw, e_iff, e_ief} = 4'b0011;
    else if (PCSrc_EX && !m_br) begin {e_pcw, e_ifw, e_iff, e_ief} = 4'b1111; ev = 1; end
    else if (!imem_ready)       begin {e_pcw, e_ifw, e_iff, e_ief} = 4'b0001; ev = 2; end
    else if (tb_load_use() && !m_br && !m_ls && !m_wt) begin
      {e_pcw, e_ifw, e_iff, e_ief} = 4'b0001; ev = 3;
    end
    else                            {e_pcw, e_ifw, e_iff, e_ief} = 4'b1100;
  endfunction

  task automatic model_advance();
    if (!reset) begin
      m_first = 1; m_br = 0; m_ls = 0; m_wt = 0; m_stall = '0; m_flush = '0;
    end else begin
      if (!m_first) begin
        if (!e_pcw) m_stall = m_stall + 32'd1;
        if (e_iff)  m_flush = m_flush + 32'd1;
      end
      m_first = 0; m_br = (ev == 1); m_wt = (ev == 2); m_ls = (ev == 3);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic clock();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic benign();
    MemRead_EX = 0; RD_EX = 0; RS1_ID = 0; RS2_ID = 0;
    OPCODE_ID = 7'b0010011; PCSrc_EX = 0; imem_ready = 1;
  endtask

  task automatic test_reset();
    benign();
    reset = 0;
    settle();
    n_cmp++;
    if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush} !== 4'b0011) begin
      n_err++; $display("FAIL reset_pre got=%b exp=0011",
                        {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush});
    end
    clock();
    for (int i = 0; i < 2; i++) begin
      settle();
      n_cmp++;
      if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, state_o} !== {4'b0011, S_RST}) begin
        n_err++; $display("FAIL reset_hold got=%b/%0d exp=0011/0",
                          {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush}, state_o);
      end
      clock();
    end
    reset = 1;
    settle();
    n_cmp++;
    if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, state_o} !== {4'b0011, S_RST}) begin
      n_err++; $display("FAIL reset_release1 got=%b/%0d exp=0011/0",
                        {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush}, state_o);
    end
`ifdef HAZARD_PERF_EN
    n_cmp++;
    if ({stall_cycles, flush_events} !== 64'd0) begin
      n_err++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_events);
    end
`endif
    clock();
    settle();
    n_cmp++;
    if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, state_o} !== {4'b1100, S_RUN}) begin
      n_err++; $display("FAIL reset_run got=%b/%0d exp=1100/1",
                        {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush}, state_o);
    end
    clock();
  endtask

  // Applies the current inputs for one cycle and compares against the model.
  task automatic check_cycle(input string tag);
    settle();
    n_cmp++;
    if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush} !== {e_pcw, e_ifw, e_iff, e_ief} ||
        state_o !== e_state) begin
      n_err++; $display("FAIL %s got=%b/%0d exp=%b/%0d", tag,
                        {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush}, state_o,
                        {e_pcw, e_ifw, e_iff, e_ief}, e_state);
    end
    clock();
  endtask

  task automatic test_load_use();
    benign();
    MemRead_EX = 1; RD_EX = 5; RS1_ID = 5; OPCODE_ID = 7'b0110011;
    settle();
    n_cmp++;
    if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, state_o} !== {4'b0001, S_RUN}) begin
      n_err++; $display("FAIL lu_stall got=%b/%0d exp=0001/1",
                        {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush}, state_o);
    end
    clock();
    settle();
    n_cmp++;
    if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, state_o} !== {4'b1100, S_LSTALL}) begin
      n_err++; $display("FAIL lu_release got=%b/%0d exp=1100/2",
                        {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush}, state_o);
    end
    clock();
    RD_EX = 0; RS1_ID = 0;
    check_cycle("lu_rd0");
    RD_EX = 5; RS1_ID = 5; OPCODE_ID = 7'b0110111;
    check_cycle("lu_lui");
    OPCODE_ID = 7'b0100011; RS1_ID = 1; RS2_ID = 5;
    check_cycle("lu_store_rs2");
    benign();
    check_cycle("lu_after");
  endtask

  task automatic test_branch();
    benign();
    PCSrc_EX = 1;
    settle();
    n_cmp++;
    if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, state_o} !== {4'b1111, S_RUN}) begin
      n_err++; $display("FAIL br_take got=%b/%0d exp=1111/1",
                        {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush}, state_o);
    end
    clock();
    PCSrc_EX = 0; MemRead_EX = 1; RD_EX = 7; RS1_ID = 7; OPCODE_ID = 7'b0110011;
    settle();
    n_cmp++;
    if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, state_o} !== {4'b1100, S_BFLUSH}) begin
      n_err++; $display("FAIL br_window got=%b/%0d exp=1100/3",
                        {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush}, state_o);
    end
    clock();
    benign();
    check_cycle("br_run");
  endtask

  task automatic test_iwait();
    logic [31:0] s0;
    benign();
    s0 = m_stall;
    imem_ready = 0;
    for (int i = 0; i < 4; i++) check_cycle("iw_hold");
    imem_ready = 1;
    settle();
    n_cmp++;
    if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, state_o} !== {4'b1100, S_IWAIT}) begin
      n_err++; $display("FAIL iw_ready got=%b/%0d exp=1100/4",
                        {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush}, state_o);
    end
`ifdef HAZARD_PERF_EN
    n_cmp++;
    if (stall_cycles - s0 !== 32'd4) begin
      n_err++; $display("FAIL iw_stall_count got=%0d exp=4", stall_cycles - s0);
    end
`endif
    clock();
    check_cycle("iw_run");
  endtask

  task automatic test_branch_wait();
    logic [31:0] f0;
    benign();
    f0 = m_flush;
    PCSrc_EX = 1; imem_ready = 0;
    settle();
    n_cmp++;
    if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush} !== 4'b1111) begin
      n_err++; $display("FAIL bw_branch got=%b exp=1111",
                        {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush});
    end
    clock();
    PCSrc_EX = 0;
    check_cycle("bw_bflush_wait");
    imem_ready = 1;
    settle();
    n_cmp++;
    if (state_o !== S_IWAIT) begin
      n_err++; $display("FAIL bw_iwait got=%0d exp=4", state_o);
    end
`ifdef HAZARD_PERF_EN
    n_cmp++;
    if (flush_events - f0 !== 32'd1) begin
      n_err++; $display("FAIL bw_flush_count got=%0d exp=1", flush_events - f0);
    end
`endif
    clock();
    check_cycle("bw_run");
  endtask

  task automatic test_reset_mid();
    benign();
    imem_ready = 0;
    check_cycle("rm_enter");
    check_cycle("rm_iwait");
`ifdef HAZARD_PERF_EN
    settle();
    force dut.stall_q = 32'hFFFF_FFFF;
    #1 release dut.stall_q;
    m_stall = 32'hFFFF_FFFF;
    n_cmp++;
    if (stall_cycles !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL wrap_preload got=%h exp=ffffffff", stall_cycles);
    end
    clock();
    settle();
    n_cmp++;
    if (stall_cycles !== 32'd0) begin
      n_err++; $display("FAIL wrap_zero got=%h exp=0", stall_cycles);
    end
    clock();
`endif
    reset = 0;
    check_cycle("rm_assert");
    settle();
    n_cmp++;
    if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, state_o} !== {4'b0011, S_RST}) begin
      n_err++; $display("FAIL rm_rst got=%b/%0d exp=0011/0",
                        {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush}, state_o);
    end
    clock();
    reset = 1; imem_ready = 1;
    check_cycle("rm_release");
    check_cycle("rm_run");
  endtask

  task automatic test_random();
    logic [6:0] ops [8];
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011,
            7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011};
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 49) != 0);
      MemRead_EX = $urandom_range(0, 1);
      RD_EX      = 5'($urandom_range(0, 3));
      RS1_ID     = 5'($urandom_range(0, 3));
      RS2_ID     = 5'($urandom_range(0, 3));
      OPCODE_ID  = ops[$urandom_range(0, 7)];
      PCSrc_EX   = ($urandom_range(0, 6) == 0);
      imem_ready = ($urandom_range(0, 4) != 0);
      settle();
      n_cmp++;
      if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush} !== {e_pcw, e_ifw, e_iff, e_ief} ||
          state_o !== e_state) begin
        n_err++; $display("FAIL rand c=%0d got=%b/%0d exp=%b/%0d", c,
                          {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush}, state_o,
                          {e_pcw, e_ifw, e_iff, e_ief}, e_state);
      end
`ifdef HAZARD_PERF_EN
      n_cmp++;
      if (stall_cycles !== m_stall || flush_events !== m_flush) begin
        n_err++; $display("FAIL rand_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c,
                          stall_cycles, flush_events, m_stall, m_flush);
      end
`endif
      clock();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_iwait();
    test_branch_wait();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
